// File: rtl/absdiff_iter_rtl.sv
// Iterative |in0 - in1| on one shared subtractor; val 2 cycles after accept (3 if swapped).
// One transaction in flight; DONE holds out/ostream_val until ostream_rdy, inputs ignored meanwhile.
module absdiff_iter_rtl #(
  parameter int nbits = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] out
);

  typedef enum logic [1:0] {IDLE, SUB, SWAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [nbits-1:0] a_reg, b_reg, result_reg;
  logic [nbits-1:0] sub_x, sub_y, diff;
  logic             bout;
  logic             accept, ld_result;

  // Single subtractor; SWAP reverses its operands instead of adding a second one
  always_comb begin
    sub_x = a_reg;
    sub_y = b_reg;
    if (state == SWAP) begin
      sub_x = b_reg;
      sub_y = a_reg;
    end
    {bout, diff} = {1'b0, sub_x} - {1'b0, sub_y};
  end

  always_comb begin
    state_nxt   = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    accept      = 1'b0;
    ld_result   = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          accept    = 1'b1;
          state_nxt = SUB;
        end
      end
      SUB: begin
        if (!bout) begin
          ld_result = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = SWAP;
        end
      end
      SWAP: begin
        ld_result = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= in0;
        b_reg <= in1;
      end
      if (ld_result) result_reg <= diff;
    end
  end

  assign out = result_reg;

endmodule

// File: tb/tb_absdiff_iter_rtl.sv
// Directed + exhaustive bench for absdiff_iter_rtl; expected results come from a |a-b| scoreboard queue.
module tb_absdiff_iter_rtl;

  logic       clk = 1'b0;
  logic       rst;
  logic       istream_val;
  logic       istream_rdy;
  logic [3:0] in0, in1;
  logic       ostream_val;
  logic       ostream_rdy;
  logic [3:0] out;

  int         n_vec = 0;
  int         n_err = 0;
  int         exp_q[$];

  absdiff_iter_rtl #(.nbits(4)) dut (
    .clk(clk), .rst(rst),
    .istream_val(istream_val), .istream_rdy(istream_rdy),
    .in0(in0), .in1(in1),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge after the result is shown.
  task automatic present(input int a, input int b, output int lat);
    in0 = 4'(a);
    in1 = 4'(b);
    istream_val = 1'b1;
    exp_q.push_back(absdiff(a, b));
    @(posedge clk); #1;
    istream_val = 1'b0;
    in0 = 4'($urandom_range(15));
    in1 = 4'($urandom_range(15));
    // lat counts the presenting cycle as 0
    lat = 1;
    while (!ostream_val && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic txn(input string tag, input int a, input int b);
    int lat;
    chk({tag, "_rdy_before"}, istream_rdy, 1);
    present(a, b, lat);
    chk({tag, "_val"}, ostream_val, 1);
    chk({tag, "_lat"}, lat, (a >= b) ? 2 : 3);
    chk({tag, "_out"}, out, exp_q.pop_front());
    @(posedge clk); #1;
    chk({tag, "_val_after"}, ostream_val, 0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    in0 = 4'd0;
    in1 = 4'd0;

    // Reset
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_rdy", istream_rdy, 1);
    chk("reset_val", ostream_val, 0);
    chk("reset_out", out, 0);
    @(negedge clk);

    // Directed cases
    txn("sub_9_3", 9, 3);
    txn("swap_3_9", 3, 9);
    txn("max_15_0", 15, 0);
    txn("max_0_15", 0, 15);
    txn("equal_7_7", 7, 7);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        txn("sweep", a, b);

    // Back-pressure in DONE
    ostream_rdy = 1'b0;
    present(2, 10, lat);
    chk("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      istream_val = 1'b1;
      in0 = 4'd1;
      in1 = 4'd1;
      @(posedge clk); #1;
      chk("bp_val_hold", ostream_val, 1);
      chk("bp_out_hold", out, 8);
      chk("bp_rdy_low", istream_rdy, 0);
      @(negedge clk);
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rdy", istream_rdy, 1);
    chk("bp_release_val", ostream_val, 0);
    chk("bp_out_after", out, exp_q.pop_front());
    @(negedge clk);

    // Reset while in SUB
    in0 = 4'd4; in1 = 4'd12; istream_val = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_sub_rdy", istream_rdy, 1);
    chk("rst_sub_val", ostream_val, 0);
    chk("rst_sub_out", out, 0);
    @(negedge clk);

    // Leave a nonzero result behind, then reset while in SWAP
    txn("pre_swap", 1, 14);
    in0 = 4'd3; in1 = 4'd9; istream_val = 1'b1;
    @(posedge clk); #1;
    istream_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_swap_rdy", istream_rdy, 1);
    chk("rst_swap_val", ostream_val, 0);
    chk("rst_swap_out", out, 0);
    @(negedge clk);

    // Reset beats a simultaneous handshake
    in0 = 4'd8; in1 = 4'd2; istream_val = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    istream_val = 1'b0;
    chk("rst_override_rdy", istream_rdy, 1);
    @(posedge clk); #1;
    chk("rst_override_val", ostream_val, 0);
    @(negedge clk);

    txn("post_rst_5_1", 5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
